audio_dma_sequencer: RTL and testbench

Bus-master sequencer that streams stereo sample frames from system memory into the audio FIFO write port. It reads 32-bit words over Wishbone, packs left/right pairs into 48-bit frames, and throttles on FIFO fullness. It runs in one-shot or looping (ring-buffer) mode, so the CPU only configures it and reacts to `done`/`err`. It sits between the system bus and the audio block's `audio_data`/`audio_valid` write path, in parallel with CPU register writes.

---
 rtl/audio_dma_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_audio_dma_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dma_sequencer.sv
// audio_dma_sequencer: Wishbone bus master that fetches left/right sample words
// from a memory buffer, packs them into 48-bit stereo frames and pushes them
// into the audio FIFO, throttled by fifo_full. One-shot by default; define
// AUDIO_DMA_LOOP_EN to build the ring-buffer (cfg_loop) restart logic.
module audio_dma_sequencer #(
  parameter int unsigned LEN_BITS      = 16,
  parameter int unsigned FIFO_LEN_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_enable,
  input  logic [31:0]         cfg_base,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic                cfg_loop,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         m_adr_o,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  output logic                m_we_o,
  output logic [3:0]          m_sel_o,
  input  logic [31:0]         m_dat_i,
  input  logic                m_ack_i,
  input  logic                m_err_i,
  output logic [47:0]         audio_data,
  output logic                audio_valid,
  input  logic                fifo_full
);

  localparam int unsigned ADR_W = 32;
  localparam int unsigned SMP_W = 24;
  localparam int unsigned FRM_W = 2 * SMP_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_L,
    S_RD_R,
    S_PUSH,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [ADR_W-1:0]    base_q, base_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] idx_q, idx_d;
  logic [SMP_W-1:0]    left_q, left_d;
  logic [SMP_W-1:0]    right_q, right_d;
`ifdef AUDIO_DMA_LOOP_EN
  logic                loop_q, loop_d;
`endif

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cyc_q, cyc_d;
  logic [ADR_W-1:0]    adr_q, adr_d;
  logic [FRM_W-1:0]    data_q, data_d;
  logic                valid_q, valid_d;

  logic                last_c;
  logic                push_c;
  logic [ADR_W-1:0]    off_c;
  logic                unused_ok;

  assign last_c = (idx_q == len_q - LEN_BITS'(1));
  assign push_c = (state_q == S_PUSH) && cfg_enable && !fifo_full;

`ifdef AUDIO_DMA_LOOP_EN
  assign unused_ok = ^{m_dat_i[31:24], cfg_base[2:0], 32'(FIFO_LEN_BITS)};
`else
  assign unused_ok = ^{m_dat_i[31:24], cfg_base[2:0], cfg_loop, 32'(FIFO_LEN_BITS)};
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and working-register update
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    left_d  = left_q;
    right_d = right_q;
`ifdef AUDIO_DMA_LOOP_EN
    loop_d  = loop_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cfg_enable) begin
          base_d  = {cfg_base[ADR_W-1:3], 3'b000};
          len_d   = cfg_len;
          idx_d   = '0;
`ifdef AUDIO_DMA_LOOP_EN
          loop_d  = cfg_loop;
`endif
          state_d = (cfg_len == '0) ? S_DONE : S_RD_L;
        end
      end
      S_RD_L: begin
        if (m_err_i) begin
          state_d = S_ERR;
        end else if (m_ack_i) begin
          left_d  = m_dat_i[SMP_W-1:0];
          state_d = cfg_enable ? S_RD_R : S_IDLE;
        end
      end
      S_RD_R: begin
        if (m_err_i) begin
          state_d = S_ERR;
        end else if (m_ack_i) begin
          right_d = m_dat_i[SMP_W-1:0];
          state_d = cfg_enable ? S_PUSH : S_IDLE;
        end
      end
      S_PUSH: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else if (push_c) begin
          if (last_c) begin
            idx_d   = '0;
`ifdef AUDIO_DMA_LOOP_EN
            state_d = loop_q ? S_RD_L : S_DONE;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + LEN_BITS'(1);
            state_d = S_RD_L;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, aligned with the next state
  always_comb begin
    off_c   = ADR_W'(idx_d) << 3;
    busy_d  = state_d inside {S_RD_L, S_RD_R, S_PUSH};
    cyc_d   = state_d inside {S_RD_L, S_RD_R};
    err_d   = (state_d == S_ERR);
    valid_d = push_c;
    done_d  = (push_c && last_c) ||
              ((state_q == S_IDLE) && cfg_enable && (cfg_len == '0));
    data_d  = data_q;
    adr_d   = '0;
    if (push_c) begin
      data_d = {left_q, right_q};
    end
    if (state_d == S_RD_L) begin
      adr_d = base_d + off_c;
    end else if (state_d == S_RD_R) begin
      adr_d = base_d + off_c + ADR_W'(4);
    end
  end

  // Working and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
`ifdef AUDIO_DMA_LOOP_EN
      loop_q  <= 1'b0;
`endif
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      right_q <= right_d;
`ifdef AUDIO_DMA_LOOP_EN
      loop_q  <= loop_d;
`endif
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign m_adr_o     = adr_q;
  assign m_cyc_o     = cyc_q;
  assign m_stb_o     = cyc_q;
  assign m_we_o      = 1'b0;
  assign m_sel_o     = 4'hF;
  assign audio_data  = data_q;
  assign audio_valid = valid_q;

endmodule

// File: tb/tb_audio_dma_sequencer.sv
// Self-checking bench for audio_dma_sequencer: Wishbone memory slave with
// programmable wait states / error injection, and a frame/address model
// computed directly from the buffer configuration.
module tb_audio_dma_sequencer;

  localparam int unsigned LB = 16;

  logic          clk, rst;
  logic          cfg_enable, cfg_loop;
  logic [31:0]   cfg_base;
  logic [LB-1:0] cfg_len;
  logic          busy, done, err;
  logic [31:0]   m_adr_o, m_dat_i;
  logic          m_cyc_o, m_stb_o, m_we_o, m_ack_i, m_err_i;
  logic [3:0]    m_sel_o;
  logic [47:0]   audio_data;
  logic          audio_valid, fifo_full;

  int n_checks = 0;
  int n_fail   = 0;

  audio_dma_sequencer #(.LEN_BITS(LB), .FIFO_LEN_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
    .busy(busy), .done(done), .err(err),
    .m_adr_o(m_adr_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .audio_data(audio_data), .audio_valid(audio_valid), .fifo_full(fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] seed;
  int          waits;
  bit          err_arm;
  logic [31:0] err_adr;
  int          wcnt;
  logic [31:0] adr_q[$];
  logic [47:0] push_q[$];
  bit          pdone_q[$];
  int          pcyc_q[$];
  int          done_cnt = 0;
  int          cyc_n = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [47:0] exp_frame(input logic [31:0] b, input int i);
    logic [31:0] a, wl, wr;
    a  = b + 32'(i) * 32'd8;
    wl = mem_word(a);
    wr = mem_word(a + 32'd4);
    return {wl[23:0], wr[23:0]};
  endfunction

  function automatic logic [31:0] exp_adr(input logic [31:0] b, input int k);
    return b + 32'(k / 2) * 32'd8 + 32'(k % 2) * 32'd4;
  endfunction

  // Memory slave: registered ack after 'waits' extra cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ack_i <= 1'b0;
      m_err_i <= 1'b0;
      m_dat_i <= '0;
      wcnt    <= 0;
    end else begin
      m_ack_i <= 1'b0;
      m_err_i <= 1'b0;
      if (m_cyc_o && m_stb_o && !m_ack_i && !m_err_i) begin
        if (wcnt < waits) begin
          wcnt <= wcnt + 1;
        end else begin
          wcnt <= 0;
          adr_q.push_back(m_adr_o);
          if (err_arm && m_adr_o == err_adr) m_err_i <= 1'b1;
          else begin
            m_ack_i <= 1'b1;
            m_dat_i <= mem_word(m_adr_o);
          end
        end
      end
    end
  end

  // Push / done monitor
  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (rst === 1'b1) begin
      if (audio_valid === 1'b1) begin
        push_q.push_back(audio_data);
        pdone_q.push_back(done);
        pcyc_q.push_back(cyc_n);
      end
      if (done === 1'b1) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    adr_q.delete();
    push_q.delete();
    pdone_q.delete();
    pcyc_q.delete();
  endtask

  task automatic start(input logic [31:0] b, input logic [LB-1:0] l, input bit lp);
    cfg_base   = b;
    cfg_len    = l;
    cfg_loop   = lp;
    cfg_enable = 1'b1;
    tick();
  endtask

  task automatic finish_job();
    cfg_enable = 1'b0;
    fifo_full  = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rand_bp, input bit scramble);
    int d0, k;
    logic [31:0] r;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      if (rand_bp) begin
        r = $urandom;
        fifo_full = r[0];
      end
      if (scramble) begin
        cfg_base = $urandom;
        r        = $urandom;
        cfg_len  = r[LB-1:0];
        cfg_loop = r[31];
      end
      tick();
      k++;
    end
    fifo_full = 1'b0;
    check({tag, "_timeout"}, 64'(done_cnt > d0), 64'd1);
  endtask

  initial begin
    int k, n, d0;
    rst = 1'b0; cfg_enable = 1'b0; cfg_base = '0; cfg_len = '0; cfg_loop = 1'b0;
    fifo_full = 1'b0; waits = 0; err_arm = 1'b0; err_adr = '0;
    seed = $urandom;
    repeat (3) tick();

    // Reset values
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cyc", 64'(m_cyc_o), 64'd0);
    check("rst_stb", 64'(m_stb_o), 64'd0);
    check("rst_adr", 64'(m_adr_o), 64'd0);
    check("rst_valid", 64'(audio_valid), 64'd0);
    check("rst_data", 64'(audio_data), 64'd0);
    check("rst_sel", 64'(m_sel_o), 64'hF);
    check("rst_we", 64'(m_we_o), 64'd0);
    rst = 1'b1;
    tick();

    // One-shot, zero-wait memory
    clear_obs();
    start(32'h1000, LB'(3), 1'b0);
    wait_done("os", 400, 1'b0, 1'b0);
    check("os_valid_with_done", 64'(audio_valid), 64'd1);
    check("os_busy_at_done", 64'(busy), 64'd0);
    check("os_pushes", 64'(push_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < push_q.size()) begin
        check($sformatf("os_frame%0d", i), 64'(push_q[i]), 64'(exp_frame(32'h1000, i)));
        check($sformatf("os_done%0d", i), 64'(pdone_q[i]), 64'(i == 2));
      end
    end
    check("os_reads", 64'(adr_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < adr_q.size()) check($sformatf("os_adr%0d", i), 64'(adr_q[i]), 64'(exp_adr(32'h1000, i)));
    if (pcyc_q.size() >= 3) begin
      check("os_spacing01", 64'(pcyc_q[1] - pcyc_q[0]), 64'd5);
      check("os_spacing12", 64'(pcyc_q[2] - pcyc_q[1]), 64'd5);
    end
    tick();
    check("os_done_one_cycle", 64'(done), 64'd0);
    check("os_idle_busy", 64'(busy), 64'd0);
    check("os_idle_cyc", 64'(m_cyc_o), 64'd0);
    repeat (5) tick();
    check("os_no_more_push", 64'(push_q.size()), 64'd3);
    finish_job();

    // Backpressure at the first push
    clear_obs();
    fifo_full = 1'b1;
    start(32'h2000, LB'(2), 1'b0);
    k = 0;
    while (adr_q.size() < 2 && k < 50) begin tick(); k++; end
    check("bp_reads_ready", 64'(adr_q.size()), 64'd2);
    repeat (11) tick();
    check("bp_no_push", 64'(push_q.size()), 64'd0);
    check("bp_no_reads", 64'(adr_q.size()), 64'd2);
    check("bp_cyc", 64'(m_cyc_o), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    fifo_full = 1'b0;
    tick();
    check("bp_valid", 64'(audio_valid), 64'd1);
    check("bp_data", 64'(audio_data), 64'(exp_frame(32'h2000, 0)));
    wait_done("bp", 200, 1'b0, 1'b0);
    check("bp_pushes", 64'(push_q.size()), 64'd2);
    if (push_q.size() >= 2) check("bp_frame1", 64'(push_q[1]), 64'(exp_frame(32'h2000, 1)));
    finish_job();

    // Loop mode
    clear_obs();
`ifdef AUDIO_DMA_LOOP_EN
    start(32'h1000, LB'(2), 1'b1);
    k = 0;
    while (push_q.size() < 5 && k < 300) begin tick(); k++; end
    check("lp_pushes", 64'(push_q.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < push_q.size()) begin
        check($sformatf("lp_frame%0d", i), 64'(push_q[i]), 64'(exp_frame(32'h1000, i % 2)));
        check($sformatf("lp_done%0d", i), 64'(pdone_q[i]), 64'(i % 2 == 1));
      end
    end
    for (int i = 0; i < 10; i++)
      if (i < adr_q.size()) check($sformatf("lp_adr%0d", i), 64'(adr_q[i]), 64'(exp_adr(32'h1000, i % 4)));
    cfg_enable = 1'b0;
    k = 0;
    while (busy && k < 50) begin tick(); k++; end
    check("lp_stop_busy", 64'(busy), 64'd0);
`else
    start(32'h1000, LB'(2), 1'b1);
    wait_done("lp", 200, 1'b0, 1'b0);
    repeat (20) tick();
    check("lp_oneshot_pushes", 64'(push_q.size()), 64'd2);
    check("lp_oneshot_reads", 64'(adr_q.size()), 64'd4);
    check("lp_oneshot_busy", 64'(busy), 64'd0);
`endif
    finish_job();

    // Bus error on the right read of frame 1
    clear_obs();
    err_arm = 1'b1;
    err_adr = 32'h300C;
    start(32'h3000, LB'(3), 1'b0);
    k = 0;
    while (err !== 1'b1 && k < 100) begin tick(); k++; end
    check("be_err", 64'(err), 64'd1);
    check("be_cyc", 64'(m_cyc_o), 64'd0);
    check("be_stb", 64'(m_stb_o), 64'd0);
    check("be_busy", 64'(busy), 64'd0);
    check("be_reads", 64'(adr_q.size()), 64'd4);
    repeat (3) tick();
    check("be_pushes", 64'(push_q.size()), 64'd1);
    if (push_q.size() >= 1) check("be_frame0", 64'(push_q[0]), 64'(exp_frame(32'h3000, 0)));
    check("be_err_sticky", 64'(err), 64'd1);
    cfg_enable = 1'b0;
    tick();
    check("be_err_clear", 64'(err), 64'd0);
    check("be_idle_busy", 64'(busy), 64'd0);
    err_arm = 1'b0;
    finish_job();

    // Abort during a 3-wait-state read
    clear_obs();
    waits = 3;
    start(32'h4000, LB'(2), 1'b0);
    check("ab_cyc_up", 64'(m_cyc_o), 64'd1);
    cfg_enable = 1'b0;
    n = 1;
    k = 0;
    while (k < 20) begin
      tick();
      k++;
      if (m_cyc_o) n++;
      else break;
    end
    check("ab_cyc_len", 64'(n), 64'(waits + 2));
    repeat (5) tick();
    check("ab_reads", 64'(adr_q.size()), 64'd1);
    check("ab_pushes", 64'(push_q.size()), 64'd0);
    check("ab_busy", 64'(busy), 64'd0);
    waits = 0;
    finish_job();

    // Zero-length buffer
    clear_obs();
    d0 = done_cnt;
    start(32'h5000, LB'(0), 1'b0);
    check("z_done", 64'(done), 64'd1);
    check("z_busy", 64'(busy), 64'd0);
    check("z_cyc", 64'(m_cyc_o), 64'd0);
    tick();
    check("z_done_pulse", 64'(done), 64'd0);
    repeat (5) tick();
    check("z_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("z_reads", 64'(adr_q.size()), 64'd0);
    check("z_pushes", 64'(push_q.size()), 64'd0);
    finish_job();

    // Randomized buffers, wait states and backpressure; first one wraps at 2^32
    for (int it = 0; it < 8; it++) begin
      logic [31:0] r, b;
      int l;
      r = $urandom;
      b = (it == 0) ? 32'hFFFF_FFF8 : (r & 32'hFFFF_FFF8);
      l = (it == 0) ? 3 : int'($urandom_range(1, 6));
      waits = int'($urandom_range(0, 2));
      clear_obs();
      start(b, LB'(l), 1'b0);
      wait_done($sformatf("rnd%0d", it), 800, 1'b1, 1'b1);
      check($sformatf("rnd%0d_pushes", it), 64'(push_q.size()), 64'(l));
      for (int i = 0; i < l; i++) begin
        if (i < push_q.size()) begin
          check($sformatf("rnd%0d_frame%0d", it, i), 64'(push_q[i]), 64'(exp_frame(b, i)));
          check($sformatf("rnd%0d_done%0d", it, i), 64'(pdone_q[i]), 64'(i == l - 1));
        end
      end
      check($sformatf("rnd%0d_reads", it), 64'(adr_q.size()), 64'(2 * l));
      for (int i = 0; i < 2 * l; i++)
        if (i < adr_q.size()) check($sformatf("rnd%0d_adr%0d", it, i), 64'(adr_q[i]), 64'(exp_adr(b, i)));
      finish_job();
    end

    // Asynchronous reset in the middle of a read
    clear_obs();
    waits = 3;
    start(32'h6000, LB'(2), 1'b0);
    check("ar_cyc_before", 64'(m_cyc_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_cyc", 64'(m_cyc_o), 64'd0);
    check("ar_stb", 64'(m_stb_o), 64'd0);
    check("ar_adr", 64'(m_adr_o), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_valid", 64'(audio_valid), 64'd0);
    check("ar_done", 64'(done), 64'd0);
    cfg_enable = 1'b0;
    waits = 0;
    tick();
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
